// File: rtl/issue_queue_pkg.sv
// Shared defines for the issue queue: default widths, NOP opcode and the null tag.
package issue_queue_pkg;

  localparam int unsigned OPENUM_LEN_DEF = 6;
  localparam int unsigned ROB_LEN_DEF    = 4;
  localparam int unsigned DATA_LEN_DEF   = 32;

  // Opcode driven on the issue port while nothing has been issued since reset.
  localparam logic [OPENUM_LEN_DEF-1:0] OPENUM_NOP = 6'h01;

  // Tag value meaning "operand already available".
  localparam logic [ROB_LEN_DEF:0] ZERO_ROB = '0;

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, CDB and execute-side signals of the issue queue.
// slave = the queue itself, master = the surrounding pipeline.
interface issue_queue_if #(
  parameter int unsigned NUM_CDB    = 2,
  parameter int unsigned DATA_LEN   = issue_queue_pkg::DATA_LEN_DEF,
  parameter int unsigned ROB_LEN    = issue_queue_pkg::ROB_LEN_DEF,
  parameter int unsigned OPENUM_LEN = issue_queue_pkg::OPENUM_LEN_DEF
);
  localparam int unsigned TAG_W = ROB_LEN + 1;

  logic                         dsp_valid;
  logic [OPENUM_LEN-1:0]        dsp_openum;
  logic [DATA_LEN-1:0]          dsp_V1;
  logic [DATA_LEN-1:0]          dsp_V2;
  logic [DATA_LEN-1:0]          dsp_pc;
  logic [DATA_LEN-1:0]          dsp_imm;
  logic [TAG_W-1:0]             dsp_Q1;
  logic [TAG_W-1:0]             dsp_Q2;
  logic [TAG_W-1:0]             dsp_rob_id;
  logic                         full;

  logic [NUM_CDB-1:0]           cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]     cdb_rob_id;
  logic [NUM_CDB*DATA_LEN-1:0]  cdb_value;

  logic                         ex_valid;
  logic                         ex_ready;
  logic [OPENUM_LEN-1:0]        ex_openum;
  logic [DATA_LEN-1:0]          ex_V1;
  logic [DATA_LEN-1:0]          ex_V2;
  logic [DATA_LEN-1:0]          ex_pc;
  logic [DATA_LEN-1:0]          ex_imm;
  logic [TAG_W-1:0]             ex_rob_id;

  modport slave (
    input  dsp_valid, dsp_openum, dsp_V1, dsp_V2, dsp_pc, dsp_imm,
           dsp_Q1, dsp_Q2, dsp_rob_id,
           cdb_valid, cdb_rob_id, cdb_value, ex_ready,
    output full, ex_valid, ex_openum, ex_V1, ex_V2, ex_pc, ex_imm, ex_rob_id
  );

  modport master (
    output dsp_valid, dsp_openum, dsp_V1, dsp_V2, dsp_pc, dsp_imm,
           dsp_Q1, dsp_Q2, dsp_rob_id,
           cdb_valid, cdb_rob_id, cdb_value, ex_ready,
    input  full, ex_valid, ex_openum, ex_V1, ex_V2, ex_pc, ex_imm, ex_rob_id
  );

endinterface

// File: rtl/issue_queue_find_first.sv
// Lowest-index set-bit finder (combinational).
module iq_find_first #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         req_i,
  output logic                     found_c_o,
  output logic [$clog2(WIDTH)-1:0] idx_c_o
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_c_o = 1'b1;
        idx_c_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Reservation-station issue queue: dispatch into the lowest free slot,
// CDB wakeup, lowest-index ready select into a registered issue port.
// Build option: IQ_DISPATCH_BYPASS_EN resolves dispatched tags against
// same-cycle CDB broadcasts.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned RS_DEPTH   = 16,
  parameter int unsigned NUM_CDB    = 2,
  parameter int unsigned DATA_LEN   = DATA_LEN_DEF,
  parameter int unsigned ROB_LEN    = ROB_LEN_DEF,
  parameter int unsigned OPENUM_LEN = OPENUM_LEN_DEF
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  issue_queue_if.slave bus
);
  localparam int unsigned TAG_W = ROB_LEN + 1;
  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  typedef struct packed {
    logic [OPENUM_LEN-1:0] op;
    logic [DATA_LEN-1:0]   v1;
    logic [DATA_LEN-1:0]   v2;
    logic [DATA_LEN-1:0]   pc;
    logic [DATA_LEN-1:0]   imm;
    logic [TAG_W-1:0]      rob;
  } iss_t;

  typedef struct packed {
    iss_t             ins;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
  } entry_t;

  localparam iss_t ISS_RESET = '{op: OPENUM_LEN'(OPENUM_NOP), v1: '0, v2: '0,
                                 pc: '0, imm: '0, rob: '0};

  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic                full_q, full_d;
  logic                ex_valid_q, ex_valid_d;
  iss_t                ex_q, ex_d;

  logic [RS_DEPTH-1:0] ready_c;
  logic                free_found_c, ready_found_c;
  logic [IDX_W-1:0]    free_idx_c, ready_idx_c;
  logic                issue_c, dispatch_c;

  // Returns {hit, value}; lowest channel wins, the null tag never matches.
  function automatic logic [DATA_LEN:0] cdb_lookup(
    input logic [TAG_W-1:0]            tag,
    input logic [NUM_CDB-1:0]          vld,
    input logic [NUM_CDB*TAG_W-1:0]    tags,
    input logic [NUM_CDB*DATA_LEN-1:0] vals
  );
    logic [DATA_LEN:0] res;
    res = '0;
    for (int c = 0; c < int'(NUM_CDB); c++) begin
      if (!res[DATA_LEN] && vld[c] && tag != TAG_W'(ZERO_ROB) &&
          tags[c*TAG_W +: TAG_W] == tag) begin
        res = {1'b1, vals[c*DATA_LEN +: DATA_LEN]};
      end
    end
    return res;
  endfunction

  // Ready = occupied with both operands available.
  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ready_c[i] = busy_q[i] && ent_q[i].q1 == TAG_W'(ZERO_ROB) &&
                   ent_q[i].q2 == TAG_W'(ZERO_ROB);
    end
  end

  iq_find_first #(.WIDTH(RS_DEPTH)) u_free_ff (
    .req_i     (~busy_q),
    .found_c_o (free_found_c),
    .idx_c_o   (free_idx_c)
  );

  iq_find_first #(.WIDTH(RS_DEPTH)) u_ready_ff (
    .req_i     (ready_c),
    .found_c_o (ready_found_c),
    .idx_c_o   (ready_idx_c)
  );

  assign issue_c    = ready_found_c && (!ex_valid_q || bus.ex_ready);
  assign dispatch_c = bus.dsp_valid && !full_q && free_found_c;

  // Next state: wakeup, issue, dispatch, then flush overrides occupancy.
  always_comb begin
    logic [DATA_LEN:0] lk;
    lk         = '0;
    ent_d      = ent_q;
    busy_d     = busy_q;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;

    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (busy_q[i]) begin
        lk = cdb_lookup(ent_q[i].q1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        if (lk[DATA_LEN]) begin
          ent_d[i].ins.v1 = lk[DATA_LEN-1:0];
          ent_d[i].q1     = TAG_W'(ZERO_ROB);
        end
        lk = cdb_lookup(ent_q[i].q2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        if (lk[DATA_LEN]) begin
          ent_d[i].ins.v2 = lk[DATA_LEN-1:0];
          ent_d[i].q2     = TAG_W'(ZERO_ROB);
        end
      end
    end

    if (ex_valid_q && bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (issue_c) begin
      ex_d                = ent_q[ready_idx_c].ins;
      ex_valid_d          = 1'b1;
      busy_d[ready_idx_c] = 1'b0;
    end

    if (dispatch_c) begin
      ent_d[free_idx_c].ins = '{op: bus.dsp_openum, v1: bus.dsp_V1, v2: bus.dsp_V2,
                                pc: bus.dsp_pc, imm: bus.dsp_imm, rob: bus.dsp_rob_id};
      ent_d[free_idx_c].q1  = bus.dsp_Q1;
      ent_d[free_idx_c].q2  = bus.dsp_Q2;
`ifdef IQ_DISPATCH_BYPASS_EN
      lk = cdb_lookup(bus.dsp_Q1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      if (lk[DATA_LEN]) begin
        ent_d[free_idx_c].ins.v1 = lk[DATA_LEN-1:0];
        ent_d[free_idx_c].q1     = TAG_W'(ZERO_ROB);
      end
      lk = cdb_lookup(bus.dsp_Q2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      if (lk[DATA_LEN]) begin
        ent_d[free_idx_c].ins.v2 = lk[DATA_LEN-1:0];
        ent_d[free_idx_c].q2     = TAG_W'(ZERO_ROB);
      end
`endif
      busy_d[free_idx_c] = 1'b1;
    end

    if (flush) begin
      busy_d     = '0;
      ex_valid_d = 1'b0;
    end

    full_d = &busy_d;
  end

  // Control and issue-port registers; reset dominates flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      full_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_q       <= ISS_RESET;
    end else begin
      busy_q     <= busy_d;
      full_q     <= full_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  // Entry payload storage; validity is carried by busy_q alone.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign bus.full      = full_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_openum = ex_q.op;
  assign bus.ex_V1     = ex_q.v1;
  assign bus.ex_V2     = ex_q.v2;
  assign bus.ex_pc     = ex_q.pc;
  assign bus.ex_imm    = ex_q.imm;
  assign bus.ex_rob_id = ex_q.rob;

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (default parameters).
module tb_issue_queue;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_errors;

  issue_queue_if #(.NUM_CDB(2), .DATA_LEN(32), .ROB_LEN(4), .OPENUM_LEN(6)) bus_if ();

  issue_queue #(.RS_DEPTH(16), .NUM_CDB(2), .DATA_LEN(32), .ROB_LEN(4), .OPENUM_LEN(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.dsp_valid  = 1'b0;
    bus_if.dsp_openum = '0;
    bus_if.dsp_V1     = '0;
    bus_if.dsp_V2     = '0;
    bus_if.dsp_pc     = '0;
    bus_if.dsp_imm    = '0;
    bus_if.dsp_Q1     = '0;
    bus_if.dsp_Q2     = '0;
    bus_if.dsp_rob_id = '0;
    bus_if.cdb_valid  = '0;
    bus_if.cdb_rob_id = '0;
    bus_if.cdb_value  = '0;
  endtask

  task automatic set_dsp(input logic [4:0] tag, input logic [4:0] q1, input logic [4:0] q2,
                         input logic [31:0] v1, input logic [31:0] v2);
    bus_if.dsp_valid  = 1'b1;
    bus_if.dsp_openum = 6'd20;
    bus_if.dsp_rob_id = tag;
    bus_if.dsp_Q1     = q1;
    bus_if.dsp_Q2     = q2;
    bus_if.dsp_V1     = v1;
    bus_if.dsp_V2     = v2;
    bus_if.dsp_pc     = 32'h1000 + {27'd0, tag};
    bus_if.dsp_imm    = 32'h10;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bus_if.ex_ready = 1'b1;
    idle_inputs();
    tick(); tick();
    n_checks++; if (bus_if.full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", bus_if.full); end
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ex_valid got %b want 0", bus_if.ex_valid); end
    n_checks++; if (bus_if.ex_openum !== 6'h01) begin n_errors++; $display("FAIL reset_openum got %h want 01", bus_if.ex_openum); end
    n_checks++; if (bus_if.ex_rob_id !== 5'd0 || bus_if.ex_V1 !== 32'd0 || bus_if.ex_pc !== 32'd0) begin
      n_errors++; $display("FAIL reset_fields got rob %h V1 %h pc %h want 0", bus_if.ex_rob_id, bus_if.ex_V1, bus_if.ex_pc); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_issue();
    bus_if.ex_ready = 1'b1;
    set_dsp(5'd5, 5'd0, 5'd0, 32'h11, 32'h22);
    tick();
    idle_inputs();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early got %b want 0", bus_if.ex_valid); end
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'd5) begin
      n_errors++; $display("FAIL basic_issue got v %b rob %h want 1 05", bus_if.ex_valid, bus_if.ex_rob_id); end
    n_checks++; if (bus_if.ex_V1 !== 32'h11 || bus_if.ex_V2 !== 32'h22 || bus_if.ex_pc !== 32'h1005 ||
                    bus_if.ex_imm !== 32'h10 || bus_if.ex_openum !== 6'd20) begin
      n_errors++; $display("FAIL basic_fields got V1 %h V2 %h pc %h imm %h op %h", bus_if.ex_V1, bus_if.ex_V2,
                           bus_if.ex_pc, bus_if.ex_imm, bus_if.ex_openum); end
    n_checks++; if (bus_if.full !== 1'b0) begin n_errors++; $display("FAIL basic_full got %b want 0", bus_if.full); end
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain got %b want 0", bus_if.ex_valid); end
  endtask

  task automatic test_wakeup();
    bus_if.ex_ready = 1'b1;
    set_dsp(5'd6, 5'd3, 5'd0, 32'h0, 32'h55);
    tick();
    idle_inputs();
    bus_if.cdb_valid  = 2'b10;
    bus_if.cdb_rob_id = {5'd3, 5'd0};
    bus_if.cdb_value  = {32'hDEAD, 32'h0};
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL wake_pending got %b want 0", bus_if.ex_valid); end
    tick();
    idle_inputs();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL wake_latency got %b want 0", bus_if.ex_valid); end
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_V1 !== 32'hDEAD || bus_if.ex_V2 !== 32'h55 || bus_if.ex_rob_id !== 5'd6) begin
      n_errors++; $display("FAIL wake_issue got v %b V1 %h V2 %h rob %h want 1 dead 55 06", bus_if.ex_valid,
                           bus_if.ex_V1, bus_if.ex_V2, bus_if.ex_rob_id); end
    // Both channels carry the same tag: channel 0 must win.
    set_dsp(5'd7, 5'd4, 5'd0, 32'h0, 32'h0);
    tick();
    idle_inputs();
    bus_if.cdb_valid  = 2'b11;
    bus_if.cdb_rob_id = {5'd4, 5'd4};
    bus_if.cdb_value  = {32'hB, 32'hA};
    tick();
    idle_inputs();
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_V1 !== 32'hA || bus_if.ex_rob_id !== 5'd7) begin
      n_errors++; $display("FAIL wake_dup_tag got v %b V1 %h rob %h want 1 a 07", bus_if.ex_valid, bus_if.ex_V1, bus_if.ex_rob_id); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus_if.ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_dsp(5'(i + 1), 5'd0, 5'd0, 32'(i + 100), 32'h0);
      else idle_inputs();
      tick();
      if (i > 0) begin
        n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'(i) || bus_if.ex_V1 !== 32'(i + 99)) begin
          n_errors++; $display("FAIL b2b_%0d got v %b rob %h V1 %h want 1 %h %h", i, bus_if.ex_valid,
                               bus_if.ex_rob_id, bus_if.ex_V1, 5'(i), 32'(i + 99)); end
      end
    end
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got %b want 0", bus_if.ex_valid); end
  endtask

  task automatic test_stall();
    bus_if.ex_ready = 1'b0;
    set_dsp(5'd3, 5'd0, 5'd0, 32'h33, 32'h0);
    tick();
    set_dsp(5'd4, 5'd0, 5'd0, 32'h44, 32'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'd3 || bus_if.ex_V1 !== 32'h33) begin
        n_errors++; $display("FAIL stall_hold_%0d got v %b rob %h V1 %h want 1 03 33", i, bus_if.ex_valid,
                             bus_if.ex_rob_id, bus_if.ex_V1); end
    end
    bus_if.ex_ready = 1'b1;
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'd4 || bus_if.ex_V1 !== 32'h44) begin
      n_errors++; $display("FAIL stall_next got v %b rob %h V1 %h want 1 04 44", bus_if.ex_valid, bus_if.ex_rob_id, bus_if.ex_V1); end
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drain got %b want 0", bus_if.ex_valid); end
  endtask

  task automatic test_full();
    bus_if.ex_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_dsp(5'(i + 1), 5'd7, 5'd0, 32'h0, 32'h0);
      tick();
      if (i == 14) begin
        n_checks++; if (bus_if.full !== 1'b0) begin n_errors++; $display("FAIL full_15 got %b want 0", bus_if.full); end
      end
      if (i == 15) begin
        n_checks++; if (bus_if.full !== 1'b1) begin n_errors++; $display("FAIL full_16 got %b want 1", bus_if.full); end
      end
    end
    set_dsp(5'd20, 5'd0, 5'd0, 32'hBAD, 32'h0);
    tick();
    idle_inputs();
    n_checks++; if (bus_if.full !== 1'b1 || bus_if.ex_valid !== 1'b0) begin
      n_errors++; $display("FAIL full_drop got full %b v %b want 1 0", bus_if.full, bus_if.ex_valid); end
    bus_if.cdb_valid  = 2'b01;
    bus_if.cdb_rob_id = {5'd0, 5'd7};
    bus_if.cdb_value  = {32'h0, 32'h77};
    tick();
    idle_inputs();
    for (int j = 0; j < 16; j++) begin
      tick();
      n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'(j + 1) || bus_if.ex_V1 !== 32'h77) begin
        n_errors++; $display("FAIL full_order_%0d got v %b rob %h V1 %h want 1 %h 77", j, bus_if.ex_valid,
                             bus_if.ex_rob_id, bus_if.ex_V1, 5'(j + 1)); end
      if (j == 0) begin
        n_checks++; if (bus_if.full !== 1'b0) begin n_errors++; $display("FAIL full_release got %b want 0", bus_if.full); end
      end
    end
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL full_extra got v %b rob %h want 0", bus_if.ex_valid, bus_if.ex_rob_id); end
  endtask

  task automatic test_flush();
    bus_if.ex_ready = 1'b0;
    set_dsp(5'd8, 5'd0, 5'd0, 32'h8, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_dsp(5'(i + 1), 5'd7, 5'd0, 32'h0, 32'h0);
      tick();
    end
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'd8) begin
      n_errors++; $display("FAIL flush_pre got v %b rob %h want 1 08", bus_if.ex_valid, bus_if.ex_rob_id); end
    set_dsp(5'd9, 5'd0, 5'd0, 32'h9, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_inputs();
    n_checks++; if (bus_if.ex_valid !== 1'b0 || bus_if.full !== 1'b0) begin
      n_errors++; $display("FAIL flush_clear got v %b full %b want 0 0", bus_if.ex_valid, bus_if.full); end
    bus_if.ex_ready   = 1'b1;
    bus_if.cdb_valid  = 2'b01;
    bus_if.cdb_rob_id = {5'd0, 5'd7};
    bus_if.cdb_value  = {32'h0, 32'h70};
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus_if.ex_valid !== 1'b0) begin
        n_errors++; $display("FAIL flush_ghost_%0d got v %b rob %h want 0", i, bus_if.ex_valid, bus_if.ex_rob_id); end
    end
  endtask

  task automatic test_reset_mid();
    bus_if.ex_ready = 1'b0;
    set_dsp(5'd11, 5'd0, 5'd0, 32'hB, 32'h0);
    tick();
    idle_inputs();
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_rob_id !== 5'd11) begin
      n_errors++; $display("FAIL rstmid_pre got v %b rob %h want 1 0b", bus_if.ex_valid, bus_if.ex_rob_id); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus_if.ex_valid !== 1'b0 || bus_if.ex_rob_id !== 5'd0 || bus_if.ex_openum !== 6'h01) begin
      n_errors++; $display("FAIL rstmid_drop got v %b rob %h op %h want 0 00 01", bus_if.ex_valid,
                           bus_if.ex_rob_id, bus_if.ex_openum); end
    bus_if.ex_ready = 1'b1;
    tick(); tick();
    n_checks++; if (bus_if.ex_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_after got %b want 0", bus_if.ex_valid); end
  endtask

  task automatic test_bypass();
    bus_if.ex_ready   = 1'b1;
    set_dsp(5'd12, 5'd0, 5'd9, 32'h1, 32'h0);
    bus_if.cdb_valid  = 2'b01;
    bus_if.cdb_rob_id = {5'd0, 5'd9};
    bus_if.cdb_value  = {32'h0, 32'h42};
    tick();
    idle_inputs();
`ifdef IQ_DISPATCH_BYPASS_EN
    tick();
    n_checks++; if (bus_if.ex_valid !== 1'b1 || bus_if.ex_V2 !== 32'h42 || bus_if.ex_rob_id !== 5'd12) begin
      n_errors++; $display("FAIL bypass_issue got v %b V2 %h rob %h want 1 42 0c", bus_if.ex_valid,
                           bus_if.ex_V2, bus_if.ex_rob_id); end
    tick();
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus_if.ex_valid !== 1'b0) begin
        n_errors++; $display("FAIL nobypass_%0d got v %b rob %h want 0", i, bus_if.ex_valid, bus_if.ex_rob_id); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus_if.ex_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_back_to_back();
    test_stall();
    test_full();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
